alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 17 +
 rtl/alu_core.sv | 72 +++++++
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcodes and FSM state encodings.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_INC        = 3'd0;
    localparam logic [2:0] OP_ADD_RIPPLE = 3'd1;
    localparam logic [2:0] OP_ADD        = 3'd2;
    localparam logic [2:0] OP_ORXOR      = 3'd3;
    localparam logic [2:0] OP_ANY        = 3'd4;
    localparam logic [2:0] OP_CONCAT     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU; op 1 goes through an explicit full-adder chain.

module alu_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module alu_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            alu_fa u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (c[i]),
                .s    (sum[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    assign cout = c[4];
endmodule

module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] y
);
    logic [3:0] rc_sum;
    logic       rc_cout;

    alu_rca4 u_rca (
        .a    (a),
        .b    (b),
        .cin  (1'b0),
        .sum  (rc_sum),
        .cout (rc_cout)
    );

    // Function select; sums are zero-extended to the 8-bit result
    always_comb begin
        y = 8'h00;
        case (op)
            OP_INC:        y = {3'b000, {1'b0, a} + 5'd1};
            OP_ADD_RIPPLE: y = {3'b000, rc_cout, rc_sum};
            OP_ADD:        y = {3'b000, {1'b0, a} + {1'b0, b}};
            OP_ORXOR:      y = {a | b, a ^ b};
            OP_ANY:        y = {7'b0, |{a, b}};
            OP_CONCAT:     y = {a, b};
            default:       y = 8'h00;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters.
// One op in flight: IDLE grants, EXEC registers the result, RESP holds it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    state_t     state;
    logic       prio;
    logic [2:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       id_q;
    logic       any_valid;
    logic       winner;
    logic [7:0] alu_y;

    // Contention goes to prio; otherwise whoever is asking wins
    assign any_valid  = req0_valid | req1_valid;
    assign winner     = (req0_valid & req1_valid) ? prio : req1_valid;
    assign req0_ready = (state == S_IDLE) & any_valid & ~winner;
    assign req1_ready = (state == S_IDLE) & any_valid &  winner;
    assign busy       = (state != S_IDLE);

    alu_core u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // Arbitration FSM with registered response and completion counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            prio      <= 1'b0;
            op_q      <= 3'd0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_id    <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        op_q  <= winner ? req1_op : req0_op;
                        a_q   <= winner ? req1_a  : req0_a;
                        b_q   <= winner ? req1_b  : req0_b;
                        id_q  <= winner;
                        prio  <= ~winner;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= alu_y;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table-driven vectors plus multi-cycle sequences,
// responses checked against a queue of expected {id, data}.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [2:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [7:0] rsp_data, op_count;
    logic       w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id, w_busy;
    logic [7:0] w_rsp_data;
    logic [1:0] w_op_count;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    // Narrow-counter copy sharing the same stimulus, to exercise wrap
    alu_arbiter #(.CNT_W(2)) u_dut_w (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data),
        .rsp_id(w_rsp_id), .busy(w_busy), .op_count(w_op_count)
    );

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t       vecs [NV];
    logic [8:0] sbq [$];
    int         total = 0;
    int         bad   = 0;
    int         exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Response scoreboard: pop on each rsp handshake, check count lags by one
    always @(negedge clk) begin
        if (!reset) begin
            check("ready_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", {23'b0, rsp_id, rsp_data}, 32'h1ff);
                end else begin
                    check("rsp_id_data", {23'b0, rsp_id, rsp_data}, {23'b0, sbq.pop_front()});
                end
                check("op_count_pre", {24'b0, op_count}, exp_cnt & 32'hff);
                check("op_count_w_pre", {30'b0, w_op_count}, exp_cnt & 32'h3);
                exp_cnt++;
            end
        end
    end

    // Drive one request, hold it until granted, then withdraw it
    task automatic send(input logic id, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp);
        bit got = 0;
        sbq.push_back({id, exp});
        @(posedge clk); #1;
        if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        if (!got) check("grant_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (sbq.size() == 0) && !busy;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    int pulses;
    int grants;
    logic [1:0] wrap_exp [5];

    initial begin
        vecs[0]  = '{1'b1, OP_INC,        4'h0, 4'h0, 8'h01};
        vecs[1]  = '{1'b1, OP_ADD_RIPPLE, 4'h0, 4'h0, 8'h00};
        vecs[2]  = '{1'b1, OP_ADD,        4'h0, 4'h0, 8'h00};
        vecs[3]  = '{1'b1, OP_ORXOR,      4'h0, 4'h0, 8'h00};
        vecs[4]  = '{1'b1, OP_ANY,        4'h0, 4'h0, 8'h00};
        vecs[5]  = '{1'b1, OP_CONCAT,     4'h0, 4'h0, 8'h00};
        vecs[6]  = '{1'b1, 3'd6,          4'h0, 4'h0, 8'h00};
        vecs[7]  = '{1'b1, 3'd7,          4'h0, 4'h0, 8'h00};
        vecs[8]  = '{1'b1, OP_ANY,        4'h0, 4'h8, 8'h01};
        vecs[9]  = '{1'b0, OP_INC,        4'hF, 4'h3, 8'h10};
        vecs[10] = '{1'b0, OP_ADD_RIPPLE, 4'h9, 4'h8, 8'h11};
        vecs[11] = '{1'b0, OP_ADD,        4'hF, 4'hF, 8'h1E};
        vecs[12] = '{1'b1, OP_ORXOR,      4'hC, 4'hA, 8'hE6};
        vecs[13] = '{1'b0, OP_CONCAT,     4'h1, 4'h2, 8'h12};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
        check("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_op_count", {24'b0, op_count}, 32'd0);
        check("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk); #1 reset = 1'b0;

        // Single request: F+1 via the ripple adder, two-edge latency
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        sbq.push_back({1'b0, 8'h10});
        req0_op = OP_ADD_RIPPLE; req0_a = 4'hF; req0_b = 4'h1; req0_valid = 1'b1;
        @(negedge clk);
        check("single_ready", {31'b0, req0_ready}, 32'd1);
        pulses = int'(req0_ready);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("single_exec_no_rsp", {31'b0, rsp_valid}, 32'd0);
        pulses += int'(req0_ready);
        @(negedge clk);
        check("single_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("single_rsp_data", {24'b0, rsp_data}, 32'h10);
        pulses += int'(req0_ready);
        check("single_ready_pulses", pulses, 32'd1);
        wait_drain();
        check("single_op_count", {24'b0, op_count}, 32'd1);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_drain();
        end

        // Backpressure; a req1 that withdraws during RESP is never executed
        rsp_ready = 1'b0;
        send(1'b0, OP_ADD, 4'h3, 4'h4, 8'h07);
        pulses = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        req1_op = OP_INC; req1_a = 4'h5; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_hold_data", {24'b0, rsp_data}, 32'h07);
            check("bp_hold_id", {31'b0, rsp_id}, 32'd0);
            check("bp_busy", {31'b0, busy}, 32'd1);
            check("bp_no_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        check("bp_op_count", {24'b0, op_count}, 32'(NV + 2));
        repeat (5) @(negedge clk);
        check("withdrawn_not_run", {30'b0, busy, rsp_valid}, 32'd0);

        // Reset during EXEC, then contention starting from prio 0
        @(posedge clk); #1;
        req0_op = OP_INC; req0_a = 4'h1; req0_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        req0_valid = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_op_count", {24'b0, op_count}, 32'd0);
        check("rst_mid_op_count_w", {30'b0, w_op_count}, 32'd0);
        sbq.delete();
        exp_cnt = 0;
        req0_op = OP_ORXOR;  req0_a = 4'hA; req0_b = 4'h5; req0_valid = 1'b1;
        req1_op = OP_CONCAT; req1_a = 4'h3; req1_b = 4'hC; req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sbq.push_back({1'b0, 8'hFF});
            sbq.push_back({1'b1, 8'h3C});
        end
        @(negedge clk); #1 reset = 1'b0;
        #1;
        check("post_rst_grant", {30'b0, req1_ready, req0_ready}, 32'b01);
        grants = 1;
        for (int i = 0; i < 60 && grants < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) grants++;
        end
        check("contention_grants", grants, 32'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();
        check("contention_op_count", {24'b0, op_count}, 32'd4);

        // Narrow counter: already wrapped to 0, continues 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            send(1'b1, OP_CONCAT, 4'(i), 4'h9, {4'(i), 4'h9});
            wait_drain();
            check("wrap_count", {30'b0, w_op_count}, {30'b0, wrap_exp[i]});
        end
        check("final_op_count", {24'b0, op_count}, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
